// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor. Processes DIGIT bits per clock,
// LSB first, across a WIDTH-bit operand pair. One operation in flight.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand/command valid
//   in_ready   block can accept an operation (registered)
//   a, b       operands (WIDTH bits)
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0 = add, 1 = subtract (a - b - cin)
//   out_valid  result valid (registered)
//   out_ready  consumer accepts the result
//   sum        result (WIDTH bits); partial contents while computing
//   cout       carry out of the MSB; in subtract mode 1 = no borrow
//   ovf        two's-complement signed overflow
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [DIGIT:0]   dsum;
  logic             c_msb;
  logic [WIDTH-1:0] dig_top;
  logic [WIDTH-1:0] sum_next;

  always_comb begin
    dsum     = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the digit's top bit recovered from that bit's sum: s = a ^ b ^ c.
    c_msb    = dsum[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
    dig_top  = WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT);
    sum_next = (sum_r >> DIGIT) | dig_top;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= sub ? ~b : b;
            carry      <= cin ^ sub;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          sum_r <= sum_next;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            cout_r      <= dsum[DIGIT];
            ovf_r       <= c_msb ^ dsum[DIGIT];
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule
